// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and write-port priority helper for the rf_mp register file.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
package rf_pkg;

   localparam int RF_WIDTH  = 32;
   localparam int RF_DEPTH  = 64;
   localparam int RF_AW     = 6;
   localparam int RF_NR     = 3;
   localparam int RF_NW     = 2;

   // Widest write-port count the priority helper handles
   localparam int RF_MAX_NW = 16;

   // Highest-numbered port whose hit bit is set wins; returns 0 when none hit
   function automatic int win_port(input logic [RF_MAX_NW-1:0] hits);
      int idx;
      idx = 0;
      for (int j = 0; j < RF_MAX_NW; j++) begin
         if (hits[j]) idx = j;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rf_wr_sel.sv
// rf_wr_sel: finds the winning write port (highest enabled index) targeting one address.
// Latency: combinational.
// Backpressure: none; pure selection logic.
module rf_wr_sel
   import rf_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH,
   parameter int AW    = RF_AW,
   parameter int NW    = RF_NW,
   parameter int PW    = (NW > 1) ? $clog2(NW) : 1
)(
   input  logic [NW-1:0]       wr_en,
   input  logic [NW*AW-1:0]    wr_addr,
   input  logic [NW*WIDTH-1:0] wr_data,
   input  logic [AW-1:0]       addr,
   output logic                hit,
   output logic [WIDTH-1:0]    data,
   output logic [PW-1:0]       port
);

   logic [RF_MAX_NW-1:0] hits;

   // One match bit per enabled write port aimed at this address
   always_comb begin
      hits = '0;
      for (int j = 0; j < NW; j++) begin
         hits[j] = wr_en[j] && (wr_addr[j*AW +: AW] == addr);
      end
   end

   assign hit  = |hits;
   assign port = PW'(win_port(hits));
   assign data = wr_data[port*WIDTH +: WIDTH];

endmodule

// File: rtl/rf_mp.sv
// rf_mp: multi-port register file with per-entry valid, invalidate and fixed write priority.
// Latency: writes land on the next edge; reads combinational (READ_REG=0) or one cycle (READ_REG=1).
// Backpressure: none; every read/write/invalidate port is accepted every cycle.
module rf_mp
   import rf_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH,
   parameter int DEPTH    = RF_DEPTH,
   parameter int AW       = RF_AW,
   parameter int NR       = RF_NR,
   parameter int NW       = RF_NW,
   parameter int BYPASS   = 1,
   parameter int READ_REG = 0
)(
   input  logic                clk,
   input  logic                reset,
   input  logic [NR*AW-1:0]    rd_addr,
   output logic [NR*WIDTH-1:0] rd_data,
   output logic [NR-1:0]       rd_valid,
   input  logic [NW-1:0]       wr_en,
   input  logic [NW*AW-1:0]    wr_addr,
   input  logic [NW*WIDTH-1:0] wr_data,
   input  logic                inv_en,
   input  logic [AW-1:0]       inv_addr
);

   localparam int          PW      = (NW > 1) ? $clog2(NW) : 1;
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             vld [DEPTH];

   // Write path: one selector per entry. Out-of-range write addresses match no entry.
   logic             w_hit  [DEPTH];
   logic [WIDTH-1:0] w_data [DEPTH];
   logic [PW-1:0]    w_port [DEPTH];

   for (genvar e = 0; e < DEPTH; e++) begin : g_wsel
      rf_wr_sel #(.WIDTH(WIDTH), .AW(AW), .NW(NW), .PW(PW)) u_sel (
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .addr    (AW'(e)),
         .hit     (w_hit[e]),
         .data    (w_data[e]),
         .port    (w_port[e])
      );
      // Winning data must be the data presented on the winning port
      always_comb assert (!w_hit[e] || w_data[e] == wr_data[w_port[e]*WIDTH +: WIDTH]);
   end

   // Storage update: reset clears all; a landing write beats a same-cycle invalidate
   always_ff @(posedge clk) begin
      for (int e = 0; e < DEPTH; e++) begin
         if (reset) begin
            mem[e] <= '0;
            vld[e] <= 1'b0;
         end else if (w_hit[e]) begin
            mem[e] <= w_data[e];
            vld[e] <= 1'b1;
         end else if (inv_en && inv_addr == AW'(e)) begin
            vld[e] <= 1'b0;
         end
      end
   end

   // Bypass path: one selector per read port
   logic             b_hit  [NR];
   logic [WIDTH-1:0] b_data [NR];
   logic [PW-1:0]    b_port [NR];

   for (genvar i = 0; i < NR; i++) begin : g_bsel
      rf_wr_sel #(.WIDTH(WIDTH), .AW(AW), .NW(NW), .PW(PW)) u_sel (
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .addr    (rd_addr[i*AW +: AW]),
         .hit     (b_hit[i]),
         .data    (b_data[i]),
         .port    (b_port[i])
      );
      // Winning data must be the data presented on the winning port
      always_comb assert (!b_hit[i] || b_data[i] == wr_data[b_port[i]*WIDTH +: WIDTH]);
   end

   logic [NR*WIDTH-1:0] c_data;
   logic [NR-1:0]       c_vld;

   // Read view: out-of-range reads 0/0; in-range reads bypass same-cycle writes when enabled.
   // Invalidates are never bypassed, so the pre-edge valid bit is returned.
   always_comb begin
      c_data = '0;
      c_vld  = '0;
      for (int i = 0; i < NR; i++) begin
         if ({1'b0, rd_addr[i*AW +: AW]} < DEPTH_L) begin
            if (BYPASS != 0 && b_hit[i]) begin
               c_data[i*WIDTH +: WIDTH] = b_data[i];
               c_vld[i]                 = 1'b1;
            end else begin
               c_data[i*WIDTH +: WIDTH] = mem[rd_addr[i*AW +: AW]];
               c_vld[i]                 = vld[rd_addr[i*AW +: AW]];
            end
         end
      end
   end

   if (READ_REG != 0) begin : g_rreg
      // Registered read stage; cleared on reset
      always_ff @(posedge clk) begin
         if (reset) begin
            rd_data  <= '0;
            rd_valid <= '0;
         end else begin
            rd_data  <= c_data;
            rd_valid <= c_vld;
         end
      end
   end else begin : g_rcomb
      assign rd_data  = c_data;
      assign rd_valid = c_vld;
   end

endmodule

// File: tb/tb_rf_mp.sv
// tb_rf_mp: directed and random checks of rf_mp against a high-level array model.
// Two instances share stimulus: default build, and DEPTH=40 / no bypass / registered reads.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_rf_mp;

   localparam int W  = 32;
   localparam int AW = 6;
   localparam int NR = 3;
   localparam int NW = 2;
   localparam int D0 = 64;
   localparam int D1 = 40;

   logic             clk = 1'b0;
   logic             reset;
   logic [AW-1:0]    ra [NR];
   logic [NW-1:0]    wr_en;
   logic [AW-1:0]    wa [NW];
   logic [W-1:0]     wd [NW];
   logic             inv_en;
   logic [AW-1:0]    inv_addr;

   logic [NR*AW-1:0] rd_addr;
   logic [NW*AW-1:0] wr_addr;
   logic [NW*W-1:0]  wr_data;
   logic [NR*W-1:0]  rd_data0, rd_data1;
   logic [NR-1:0]    rd_valid0, rd_valid1;

   assign rd_addr = {ra[2], ra[1], ra[0]};
   assign wr_addr = {wa[1], wa[0]};
   assign wr_data = {wd[1], wd[0]};

   always #5 clk = ~clk;

   rf_mp #(.WIDTH(W), .DEPTH(D0), .AW(AW), .NR(NR), .NW(NW), .BYPASS(1), .READ_REG(0)) dut0 (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .inv_en(inv_en), .inv_addr(inv_addr)
   );

   rf_mp #(.WIDTH(W), .DEPTH(D1), .AW(AW), .NR(NR), .NW(NW), .BYPASS(0), .READ_REG(1)) dut1 (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .inv_en(inv_en), .inv_addr(inv_addr)
   );

   // Reference model: index 0 mirrors dut0, index 1 mirrors dut1
   int         dep [2] = '{D0, D1};
   int         byp [2] = '{1, 0};
   logic [W-1:0] mm [2][64];
   logic         mv [2][64];
   logic [W:0]   q1 [NR];

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_comb;

   // What a read of address a should show right now (valid in bit W)
   function automatic logic [W:0] view(input int k, input int a);
      if (a >= dep[k]) return '0;
      if (byp[k] != 0) begin
         for (int j = NW-1; j >= 0; j--) begin
            if (wr_en[j] && int'(wa[j]) == a) return {1'b1, wd[j]};
         end
      end
      return {mv[k][a], mm[k][a]};
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_neg();
      logic [W:0] e;
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         if (chk_comb) begin
            e = view(0, int'(ra[i]));
            chk($sformatf("d0_data%0d", i), rd_data0[i*W +: W], e[W-1:0]);
            chk($sformatf("d0_valid%0d", i), {31'b0, rd_valid0[i]}, {31'b0, e[W]});
         end
         chk($sformatf("d1_data%0d", i), rd_data1[i*W +: W], q1[i][W-1:0]);
         chk($sformatf("d1_valid%0d", i), {31'b0, rd_valid1[i]}, {31'b0, q1[i][W]});
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      for (int i = 0; i < NR; i++) q1[i] = reset ? '0 : view(1, int'(ra[i]));
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            for (int a = 0; a < 64; a++) begin
               mm[k][a] = '0;
               mv[k][a] = 1'b0;
            end
         end else begin
            if (inv_en && int'(inv_addr) < dep[k]) mv[k][inv_addr] = 1'b0;
            for (int j = 0; j < NW; j++) begin
               if (wr_en[j] && int'(wa[j]) < dep[k]) begin
                  mm[k][wa[j]] = wd[j];
                  mv[k][wa[j]] = 1'b1;
               end
            end
         end
      end
      #1;
   endtask

   task automatic step();
      check_neg();
      edge_step();
   endtask

   task automatic set_idle();
      wr_en  = '0;
      inv_en = 1'b0;
      inv_addr = '0;
      for (int j = 0; j < NW; j++) begin
         wa[j] = '0;
         wd[j] = '0;
      end
   endtask

   task automatic read_all(input int a);
      for (int i = 0; i < NR; i++) ra[i] = AW'(a);
   endtask

   initial begin
      reset    = 1'b1;
      chk_comb = 1'b1;
      set_idle();
      read_all(0);
      for (int k = 0; k < 2; k++)
         for (int a = 0; a < 64; a++) begin
            mm[k][a] = '0;
            mv[k][a] = 1'b0;
         end
      for (int i = 0; i < NR; i++) q1[i] = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Post-reset sweep of every address on every port
      for (int a = 0; a < 64; a += NR) begin
         for (int i = 0; i < NR; i++) ra[i] = AW'((a + i) % 64);
         step();
      end
      check_neg();
      chk("rst_valid_d0", {29'b0, rd_valid0}, 32'd0);
      edge_step();

      // Two ports write different entries
      wr_en = 2'b11; wa[0] = 6'd5; wd[0] = 32'hDEADBEEF; wa[1] = 6'd9; wd[1] = 32'h12345678;
      step();
      set_idle();
      ra[0] = 6'd5; ra[1] = 6'd9; ra[2] = 6'd5;
      check_neg();
      chk("wr_p0", rd_data0[0*W +: W], 32'hDEADBEEF);
      chk("wr_p1", rd_data0[1*W +: W], 32'h12345678);
      chk("wr_p2", rd_data0[2*W +: W], 32'hDEADBEEF);
      chk("wr_vld", {29'b0, rd_valid0}, 32'd7);
      edge_step();
      check_neg();
      chk("rreg_lag", rd_data1[1*W +: W], 32'h12345678);
      edge_step();

      // Same-address conflict: higher port wins
      wr_en = 2'b11; wa[0] = 6'd7; wd[0] = 32'h1111; wa[1] = 6'd7; wd[1] = 32'h2222;
      read_all(7);
      check_neg();
      chk("conflict_byp", rd_data0[0*W +: W], 32'h2222);
      edge_step();
      set_idle();
      check_neg();
      chk("conflict", rd_data0[0*W +: W], 32'h2222);
      edge_step();

      // Bypass on dut0; dut1 captures the pre-write value
      wr_en = 2'b01; wa[0] = 6'd3; wd[0] = 32'hA5A5;
      read_all(3);
      check_neg();
      chk("byp_data", rd_data0[0*W +: W], 32'hA5A5);
      chk("byp_vld", {31'b0, rd_valid0[0]}, 32'd1);
      edge_step();
      set_idle();
      check_neg();
      chk("nobyp_old", rd_data1[0*W +: W], 32'h0);
      chk("nobyp_vld", {31'b0, rd_valid1[0]}, 32'd0);
      edge_step();

      // Write beats invalidate; invalidate alone clears valid only
      wr_en = 2'b01; wa[0] = 6'd4; wd[0] = 32'h55; inv_en = 1'b1; inv_addr = 6'd4;
      read_all(4);
      step();
      set_idle();
      inv_en = 1'b1; inv_addr = 6'd4;
      check_neg();
      chk("wr_inv_data", rd_data0[0*W +: W], 32'h55);
      chk("wr_inv_vld", {31'b0, rd_valid0[0]}, 32'd1);
      edge_step();
      inv_en = 1'b0;
      check_neg();
      chk("inv_data", rd_data0[0*W +: W], 32'h55);
      chk("inv_vld", {31'b0, rd_valid0[0]}, 32'd0);
      edge_step();

      // Address 45 is out of range for dut1 only
      wr_en = 2'b01; wa[0] = 6'd45; wd[0] = 32'hFF;
      read_all(45);
      step();
      set_idle();
      step();
      check_neg();
      chk("oor_d1_data", rd_data1[0*W +: W], 32'h0);
      chk("oor_d1_vld", {31'b0, rd_valid1[0]}, 32'd0);
      chk("inr_d0_data", rd_data0[0*W +: W], 32'hFF);
      edge_step();
      for (int a = 0; a < D1; a += NR) begin
         for (int i = 0; i < NR; i++) ra[i] = AW'((a + i) % 64);
         step();
      end

      // Random traffic with occasional reset; small address window forces collisions
      for (int n = 0; n < 400; n++) begin
         reset    = ($urandom_range(0, 39) == 0);
         chk_comb = !reset;
         wr_en    = 2'($urandom);
         for (int j = 0; j < NW; j++) begin
            wa[j] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
            wd[j] = $urandom;
         end
         inv_en   = ($urandom_range(0, 3) == 0);
         inv_addr = AW'($urandom_range(0, 15));
         for (int i = 0; i < NR; i++)
            ra[i] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
         step();
      end

      // Mid-run reset discards same-cycle writes and clears registered outputs
      reset = 1'b0;
      chk_comb = 1'b1;
      set_idle();
      wr_en = 2'b01; wa[0] = 6'd2; wd[0] = 32'h77;
      read_all(2);
      step();
      step();
      reset = 1'b1;
      chk_comb = 1'b0;
      wr_en = 2'b11; wa[0] = 6'd2; wd[0] = 32'h99; wa[1] = 6'd2; wd[1] = 32'hAA;
      step();
      reset = 1'b0;
      chk_comb = 1'b1;
      set_idle();
      check_neg();
      chk("rst_d1_data", rd_data1[0*W +: W], 32'h0);
      chk("rst_d0_data", rd_data0[0*W +: W], 32'h0);
      chk("rst_d0_vld", {31'b0, rd_valid0[0]}, 32'd0);
      edge_step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
